led_display_top: RTL and testbench



---
 rtl/led_display_pkg.sv | 32 +++
 rtl/led_display_hc595_shifter.sv | 87 ++++++++
 rtl/led_display_top.sv | 99 +++++++++
 tb/tb_led_display_top.sv | 137 +++++++++++++
 4 files changed

// File: rtl/led_display_pkg.sv
// Shared types and helpers for the 8-digit 7-segment scan display.
// Segment bytes are active-low: bit7 = dp, bits6..0 = g..a.
package led_display_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        SHIFT,
        LATCH,
        IDLE
    } state_e;

    function automatic logic [7:0] seg7(input logic [3:0] bcd);
        logic [7:0] seg;
        case (bcd)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/led_display_hc595_shifter.sv
// Serialises one 16-bit word MSB first into a 74HC595 cascade, then pulses rck.
// A start request restarts the sequence from any state.
module hc595_shifter
    import led_display_pkg::*;
#(
    parameter int unsigned SCK_HALF = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [15:0] data_i,
    output logic        ser_o,
    output logic        sck_o,
    output logic        rck_o,
    output logic        done_o
);

    state_e      state_q;
    logic [15:0] shreg_q;
    logic [3:0]  bit_q;
    logic [31:0] phase_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SHIFT;
            shreg_q <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            ser_o   <= 1'b0;
            sck_o   <= 1'b0;
            rck_o   <= 1'b0;
            done_o  <= 1'b0;
        end else if (start_i) begin
            state_q <= SHIFT;
            shreg_q <= data_i;
            bit_q   <= '0;
            phase_q <= '0;
            ser_o   <= data_i[15];
            sck_o   <= 1'b0;
            rck_o   <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                SHIFT: begin
                    if (phase_q == SCK_HALF - 1) begin
                        phase_q <= '0;
                        if (!sck_o) begin
                            sck_o <= 1'b1;
                        end else begin
                            // End of a high phase: present the next bit, or go latch.
                            sck_o <= 1'b0;
                            if (bit_q == 4'd15) begin
                                state_q <= LATCH;
                                ser_o   <= 1'b0;
                                rck_o   <= 1'b1;
                            end else begin
                                bit_q   <= bit_q + 4'd1;
                                shreg_q <= {shreg_q[14:0], 1'b0};
                                ser_o   <= shreg_q[14];
                            end
                        end
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end
                LATCH: begin
                    if (phase_q == SCK_HALF - 1) begin
                        phase_q <= '0;
                        rck_o   <= 1'b0;
                        done_o  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end
                IDLE: begin
                    ser_o <= 1'b0;
                    sck_o <= 1'b0;
                    rck_o <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/led_display_top.sv
// 8-digit BCD counter shown on a 7-segment display through two cascaded 74HC595s.
// One digit is refreshed per frame; frames start every DIGIT_CYCLES clocks.
module led_display_top
    import led_display_pkg::*;
#(
    parameter int unsigned SCK_HALF     = 4,
    parameter int unsigned DIGIT_CYCLES = 100_000,
    parameter int unsigned TICK_CYCLES  = 100_000_000
) (
    input  logic external_clk,
    input  logic external_rstn,
    output logic ser,
    output logic sck,
    output logic rck
);

    logic [NUM_DIGITS-1:0][3:0] bcd_q;
    logic [NUM_DIGITS-1:0][3:0] bcd_inc;
    logic [31:0]                tick_cnt_q;
    logic [31:0]                frame_cnt_q;
    logic [DIGIT_W-1:0]         digit_q;
    logic [DIGIT_W-1:0]         digit_next;
    logic                       start_pending_q;
    logic                       frame_done_q;
    logic                       frame_start;
    logic                       shift_done;
    logic [15:0]                frame_word;
    logic [NUM_DIGITS-1:0]      sel;

    always_comb begin
        logic carry;
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (bcd_q[i] == 4'd9) begin
                    bcd_inc[i] = 4'd0;
                end else begin
                    bcd_inc[i] = bcd_q[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

    // The frame done flag guards against restarting a shifter that is still busy.
    assign frame_start = start_pending_q ||
                         ((frame_cnt_q >= DIGIT_CYCLES - 1) && frame_done_q);
    assign digit_next  = start_pending_q ? '0 : digit_q + DIGIT_W'(1);
    assign sel         = ~(NUM_DIGITS'(1) << digit_next);
    assign frame_word  = {seg7(bcd_q[digit_next]), sel};

    always_ff @(posedge external_clk or negedge external_rstn) begin
        if (!external_rstn) begin
            tick_cnt_q <= '0;
            bcd_q      <= '0;
        end else if (tick_cnt_q == TICK_CYCLES - 1) begin
            tick_cnt_q <= '0;
            bcd_q      <= bcd_inc;
        end else begin
            tick_cnt_q <= tick_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge external_clk or negedge external_rstn) begin
        if (!external_rstn) begin
            frame_cnt_q     <= '0;
            digit_q         <= '0;
            start_pending_q <= 1'b1;
            frame_done_q    <= 1'b0;
        end else if (frame_start) begin
            frame_cnt_q     <= '0;
            digit_q         <= digit_next;
            start_pending_q <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            if (frame_cnt_q != '1) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (shift_done) begin
                frame_done_q <= 1'b1;
            end
        end
    end

    hc595_shifter #(
        .SCK_HALF(SCK_HALF)
    ) u_shifter (
        .clk_i  (external_clk),
        .rst_ni (external_rstn),
        .start_i(frame_start),
        .data_i (frame_word),
        .ser_o  (ser),
        .sck_o  (sck),
        .rck_o  (rck),
        .done_o (shift_done)
    );

endmodule

// File: tb/tb_led_display_top.sv
// Directed bench: decodes the serial link into frame words and checks them
// against hand-computed values, plus shift/latch protocol timing.
module tb_led_display_top;

    localparam int unsigned SckHalf     = 2;
    localparam int unsigned DigitCycles = 100;
    localparam int unsigned TickCycles  = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ser, sck, rck;

    int n_vec = 0;
    int n_bad = 0;

    led_display_top #(
        .SCK_HALF    (SckHalf),
        .DIGIT_CYCLES(DigitCycles),
        .TICK_CYCLES (TickCycles)
    ) dut (
        .external_clk (clk),
        .external_rstn(rst_n),
        .ser          (ser),
        .sck          (sck),
        .rck          (rck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Link monitor, sampled on the falling edge.
    logic        ser_p = 1'b0, sck_p = 1'b0, rck_p = 1'b0;
    logic [15:0] sh = '0;
    logic [15:0] frame_word [128];
    int          frame_cnt = 0;
    int          bits = 0;
    int          stable = 0;
    int          rck_w = 0;
    int          viol = 0;
    int          cyc = 0;
    int          last_rck = 0;
    bit          have_last = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            ser_p = 1'b0; sck_p = 1'b0; rck_p = 1'b0;
            bits = 0; stable = 0; rck_w = 0; sh = '0; have_last = 1'b0;
        end else begin
            if (ser == ser_p) stable++;
            else stable = 1;
            if (rck && sck) viol++;
            if (sck && !sck_p) begin
                bits++;
                sh = {sh[14:0], ser};
                // ser must have held this value through the whole low phase.
                if (stable < SckHalf + 1) viol++;
            end
            if (rck && !rck_p) begin
                check("sck_edges", bits, 16);
                if (have_last) check("rck_gap", cyc - last_rck, DigitCycles);
                last_rck  = cyc;
                have_last = 1'b1;
                if (frame_cnt < 128) frame_word[frame_cnt] = sh;
                frame_cnt++;
                bits  = 0;
                rck_w = 0;
            end
            if (rck) rck_w++;
            if (!rck && rck_p) check("rck_width", rck_w, SckHalf);
            ser_p = ser; sck_p = sck; rck_p = rck;
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (frame_cnt < target) check("wait_frames", frame_cnt, target);
    endtask

    // Frame k starts 100*k cycles after release; ticks land at cycles 999, 1999, ...
    int unsigned vec_idx [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 16, 17, 104, 105, 106, 112};
    logic [15:0] vec_word [15] = '{16'hC0FE, 16'hC0FD, 16'hC0FB, 16'hC0F7, 16'hC0EF,
                                   16'hC0DF, 16'hC0BF, 16'hC07F, 16'hC0FE, 16'hF9FE,
                                   16'hC0FD, 16'hC0FE, 16'hF9FD, 16'hC0FB, 16'hF9FE};

    initial begin
        int base;
        int n;
        repeat (4) begin
            @(negedge clk);
            check("rst_out", {29'd0, ser, sck, rck}, 32'd0);
        end
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b1;

        wait_frames(113, 12000);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("frame%0d", vec_idx[i]), {16'd0, frame_word[vec_idx[i]]},
                  {16'd0, vec_word[i]});
        end

        // Reset in the middle of a shift, with sck high.
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(sck === 1'b1 && bits >= 5) && n < 300);
        check("mid_shift_found", {31'd0, sck}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {29'd0, ser, sck, rck}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        base = frame_cnt;
        wait_frames(base + 2, 400);
        check("post_rst_d0", {16'd0, frame_word[base]}, 32'h0000C0FE);
        check("post_rst_d1", {16'd0, frame_word[base + 1]}, 32'h0000C0FD);
        check("protocol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
